// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // One bit time at 200 MHz / 9600 baud
    localparam int CLK_PER_BIT     = 20833;
    localparam int DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: scans the request vector starting at ptr and wrapping,
// returning a one-hot grant plus the winning index (grant is zero when no request).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic          found_s;
    logic [IW-1:0] pos_s;

    // First requester at or after ptr, modulo N
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        pos_s   = '0;
        for (int k = 0; k < N; k++) begin
            pos_s = IW'((int'(ptr) + k) % N);
            if (!found_s && req[pos_s]) begin
                found_s      = 1'b1;
                grant[pos_s] = 1'b1;
                idx          = pos_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding bytes from NUM_REQ requesters into one UART transmitter.
// Optional tx_done watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int GAP_CYCLES     = CLK_PER_BIT,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       err_timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_tx_sched: illegal parameter value");
    end

    state_t         state_r;
    logic [IW-1:0]  ptr_r;
    logic [GW-1:0]  gap_cnt_r;
    logic [NUM_REQ-1:0] grant_s;
    logic [IW-1:0]  win_idx_s;
    logic [7:0]     win_byte_s;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (win_idx_s)
    );

    // Byte of the winning requester (grant is one-hot or zero)
    always_comb begin
        win_byte_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_byte_s = win_byte_s | ({8{grant_s[i]}} & req_data[8*i +: 8]);
        end
    end

    // Accept strobe only while idle
    always_comb begin
        if (state_r == ST_IDLE) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] WD_ONE  = TW'(1);
    logic [TW-1:0] wd_cnt_r;
    logic          err_timeout_r;
    assign err_timeout = err_timeout_r;
`else
    assign err_timeout = 1'b0;
`endif

    // Scheduler FSM with registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            gap_cnt_r  <= '0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            grant_id   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            wd_cnt_r      <= '0;
            err_timeout_r <= 1'b0;
`endif
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            err_timeout_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (|req_valid) begin
                        state_r  <= ST_START;
                        tx_start <= 1'b1;
                        tx_data  <= win_byte_s;
                        grant_id <= win_idx_s;
                        ptr_r    <= (win_idx_s == LAST_REQ) ? '0 : win_idx_s + ONE_IDX;
                        busy     <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                // tx_done here is deliberately not looked at
                ST_START: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        frame_done <= 1'b1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                        wd_cnt_r <= '0;
`endif
                        if (GAP_CYCLES > 0) begin
                            state_r <= ST_GAP;
                        end else begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    end else if (wd_cnt_r == WD_LAST) begin
                        err_timeout_r <= 1'b1;
                        wd_cnt_r      <= '0;
                        state_r       <= ST_IDLE;
                        busy          <= 1'b0;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_ONE;
                    end
`else
                    end else begin
                        state_r <= ST_WAIT;
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_r <= '0;
                        state_r   <= ST_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (NUM_REQ=4, GAP_CYCLES=5, TIMEOUT_CYCLES=100).
module tb_uart_tx_sched;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        frame_done;
    logic        err_timeout;

    int tests = 0;
    int fails = 0;
    int n;
    int seen_fd;
    int seen_err;

    uart_tx_sched #(.NUM_REQ(4), .GAP_CYCLES(5), .TIMEOUT_CYCLES(100)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        sys_rst   = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        tx_done   = 1'b0;
        repeat (3) tick();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        sys_rst = 1'b0;
        tick();

        // Single request from requester 2
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        chk("single_tx_start", 32'(tx_start), 32'd1);
        chk("single_tx_data", 32'(tx_data), 32'hA5);
        chk("single_grant_id", 32'(grant_id), 32'd2);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_ready_gone", 32'(req_ready), 32'd0);
        tick();
        chk("single_start_pulse", 32'(tx_start), 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("single_frame_done", 32'(frame_done), 32'd1);
        chk("single_fd_grant", 32'(grant_id), 32'd2);
        repeat (4) tick();
        chk("single_gap_busy", 32'(busy), 32'd1);
        tick();
        chk("single_idle_busy", 32'(busy), 32'd0);

        // Round-robin from reset with all four requesting
        sys_rst = 1'b1;
        tick();
        sys_rst   = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h4433_2211;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk("rr_grant", 32'(grant_id), 32'(k % 4));
            chk("rr_tx_data", 32'(tx_data), 32'((k % 4 + 1) * 17));
            chk("rr_tx_start", 32'(tx_start), 32'd1);
            chk("rr_ready_1cyc", 32'(req_ready), 32'd0);
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            chk("rr_frame_done", 32'(frame_done), 32'd1);
            n = 0;
            while (req_ready == 4'b0000 && n < 20) begin
                tick();
                n++;
            end
            chk("rr_gap_cycles", 32'(n), 32'd5);
        end

        // tx_done during START is ignored; non-granted changes do not disturb the frame
        req_valid = 4'b1000;
        req_data  = 32'h5C00_0000;
        #1;
        chk("early_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        tx_done   = 1'b1;
        tick();
        tx_done   = 1'b0;
        req_valid = 4'b0011;
        req_data  = 32'h0000_EEFF;
        #1;
        chk("early_no_fd", 32'(frame_done), 32'd0);
        chk("early_busy", 32'(busy), 32'd1);
        chk("early_ready_wait", 32'(req_ready), 32'd0);
        tick();
        chk("early_still_wait", 32'(frame_done), 32'd0);
        chk("early_data_stable", 32'(tx_data), 32'h5C);
        req_valid = 4'b0000;
        tx_done   = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("early_fd", 32'(frame_done), 32'd1);
        chk("early_fd_grant", 32'(grant_id), 32'd3);
        tick();
        chk("early_fd_once", 32'(frame_done), 32'd0);
        repeat (4) tick();
        chk("early_idle", 32'(busy), 32'd0);

        // Reset during WAIT
        req_valid = 4'b0100;
        req_data  = 32'h0077_0000;
        tick();
        req_valid = 4'b0000;
        tick();
        sys_rst = 1'b1;
        tick();
        tx_done = 1'b1;
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        chk("mid_rst_grant", 32'(grant_id), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_start", 32'(tx_start), 32'd0);
        tick();
        tx_done = 1'b0;
        chk("mid_rst_no_fd", 32'(frame_done), 32'd0);
        sys_rst   = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h4433_2211;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_no_start", 32'(tx_start), 32'd0);
        chk("post_rst_no_fd", 32'(frame_done), 32'd0);
        tick();
        req_valid = 4'b0000;
        chk("post_rst_grant", 32'(grant_id), 32'd0);
        chk("post_rst_start", 32'(tx_start), 32'd1);
        tick();

        // tx_done withheld in WAIT
        seen_fd  = 0;
        seen_err = 0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        n = 0;
        while (err_timeout == 1'b0 && n < 200) begin
            tick();
            n++;
            if (frame_done) seen_fd++;
        end
        chk("wd_cycles", 32'(n), 32'd100);
        chk("wd_busy", 32'(busy), 32'd0);
        chk("wd_no_fd", 32'(seen_fd), 32'd0);
        tick();
        chk("wd_pulse", 32'(err_timeout), 32'd0);
`else
        for (int c = 0; c < 150; c++) begin
            tick();
            if (err_timeout) seen_err++;
            if (frame_done) seen_fd++;
        end
        chk("nowd_busy", 32'(busy), 32'd1);
        chk("nowd_no_err", 32'(seen_err), 32'd0);
        chk("nowd_no_fd", 32'(seen_fd), 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("nowd_fd", 32'(frame_done), 32'd1);
        chk("nowd_data", 32'(tx_data), 32'h11);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters sharing one UART transmitter; legal range 2..8.
REQ-002 Parameter GAP_CYCLES, default 20833: idle sys_clk cycles inserted after each frame (one bit time at 200 MHz / 9600); 0 means no gap.
REQ-003 Parameter TIMEOUT_CYCLES, default 250000: tx_done watchdog limit; used only when UART_TX_SCHED_TIMEOUT_EN is defined.
REQ-004 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-005 sys_rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester byte-pending flag, held until accepted.
REQ-007 req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
REQ-008 req_ready  out  NUM_REQ  one-hot accept strobe; byte i is taken when req_valid[i] and req_ready[i] are both high.
REQ-009 tx_start  out  1  one-cycle pulse that launches a frame on the transmitter.
REQ-010 tx_data  out  8  byte for the transmitter; stable from the tx_start cycle until tx_done.
REQ-011 tx_done  in  1  one-cycle pulse from the transmitter when the stop bit completes.
REQ-012 grant_id  out  $clog2(NUM_REQ)  index of the requester that owns the current frame.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 frame_done  out  1  one-cycle pulse when a frame completes; grant_id is valid in the same cycle.
REQ-015 err_timeout  out  1  one-cycle pulse on watchdog expiry; tied 0 when the feature is compiled out.

Function
REQ-016 FSM states: IDLE, START, WAIT, GAP; every transition SHALL be registered.
REQ-017 IDLE: when any req_valid is high, drive req_ready one-hot to the winner, register its byte into tx_data and its index into grant_id, and go to START; otherwise stay in IDLE.
REQ-018 req_ready SHALL be combinational, nonzero only in IDLE, and zero whenever req_valid is all zero.
REQ-019 Arbitration SHALL be round-robin: search starts at (last granted + 1) mod NUM_REQ and wraps; the pointer updates only on accept.
REQ-020 START: assert tx_start for exactly one cycle, then go to WAIT; latency from accept to tx_start is 1 cycle.
REQ-021 WAIT: on tx_done, pulse frame_done; go to GAP if GAP_CYCLES > 0, else to IDLE.
REQ-022 tx_done outside WAIT SHALL be ignored, including a tx_done in the START cycle.
REQ-023 GAP: count exactly GAP_CYCLES cycles, then go to IDLE; requests are not accepted during GAP.
REQ-024 Changes to req_valid or req_data of a non-granted requester SHALL NOT affect the frame in flight.
REQ-025 Gap and watchdog counters SHALL be sized to their parameter with $clog2 and SHALL NOT wrap.

Reset
REQ-026 While sys_rst is high, the block SHALL hold these reset values: state IDLE, RR pointer so requester 0 has top priority, tx_start 0, tx_data 0, grant_id 0, busy 0, frame_done 0, err_timeout 0, counters 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no frame_done, and no tx_start SHALL be issued in the cycle after reset is released.

Configuration
REQ-028 With UART_TX_SCHED_TIMEOUT_EN defined, a WAIT lasting TIMEOUT_CYCLES cycles SHALL pulse err_timeout, suppress frame_done, and go to IDLE.
REQ-029 Without UART_TX_SCHED_TIMEOUT_EN, WAIT SHALL last indefinitely, the watchdog counter SHALL be absent, and err_timeout SHALL be constant 0.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state enum typedef, the CLK_PER_BIT constant (20833), and the default NUM_REQ.
REQ-031 Round-robin selection SHALL be the sub-module rr_arbiter (inputs: request vector and pointer; outputs: one-hot grant and index).

Verification
REQ-032 Single request: req_valid=4'b0100, req_data[23:16]=8'hA5 -> req_ready=4'b0100 for 1 cycle, tx_start next cycle, tx_data=8'hA5, grant_id=2, frame_done on tx_done.
REQ-033 All four requesting continuously from reset -> grant order 0,1,2,3,0; each req_ready pulse lasts one cycle.
REQ-034 GAP_CYCLES=5, back-to-back requests -> exactly 5 cycles from frame_done to the next req_ready.
REQ-035 tx_done pulsed during START, then again in WAIT -> only the second pulse completes the frame; exactly one frame_done.
REQ-036 sys_rst asserted during WAIT -> all outputs return to reset values and no frame_done; after release, requester 0 wins a simultaneous 4'b1111 request.
REQ-037 With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=100, tx_done withheld -> err_timeout pulses after 100 WAIT cycles, busy drops, no frame_done.
